// File: rtl/bin_to_digits4.sv
// -----------------------------------------------------------------------------
// bin_to_digits4
//
// Converts a signed or unsigned binary operand into four display-digit codes
// for the 4-digit seven-segment scanner. Codes 0x0-0x9 are decimal digits and
// 0xA is the minus sign. The conversion runs as an iterative double-dabble
// (shift-add-3): one operand bit per clock.
//
// The digit outputs are only updated on the final edge of a conversion. The
// display therefore never shows intermediate BCD values.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      conversion request, sampled only while idle
//   value      in   WIDTH  operand, captured on the edge that accepts start
//   is_signed  in   1      1: value is two's complement, 0: unsigned
//   busy       out  1      conversion in progress (state != IDLE)
//   done       out  1      one-cycle pulse: new l3..l0 / ovf are valid
//   ovf        out  1      last result did not fit in four digit positions
//   l3         out  4      leftmost digit code (sign position)
//   l2         out  4      digit code
//   l1         out  4      digit code
//   l0         out  4      rightmost digit code
//
// Handshake
//   A request is accepted on a rising edge where start=1 and busy=0. That
//   edge captures value and is_signed. busy stays high until the edge that
//   raises done, and start is ignored while busy is high; it is not queued.
//   done is high for exactly one cycle. A start presented during that cycle
//   is accepted, because the block is already idle.
//
// Parameters
//   WIDTH  operand width, legal range 4..16. The BCD scratch is five digits
//          wide, which is enough for 2^16-1.
// -----------------------------------------------------------------------------
module bin_to_digits4 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       l3,
    output logic [3:0]       l2,
    output logic [3:0]       l1,
    output logic [3:0]       l0
);

    localparam int          BCD_DIGITS = 5;
    localparam int          BCD_W      = 4 * BCD_DIGITS;
    localparam logic [4:0]  LAST_BIT   = 5'(WIDTH - 1);
    localparam logic [3:0]  CODE_MINUS = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    // The state register is named plainly so a checker can bind to it
    // hierarchically.
    state_t             state;
    logic               neg;
    logic [WIDTH-1:0]   mag;
    logic [BCD_W-1:0]   bcd;
    logic [4:0]         bit_cnt;

    // Combinational helpers
    logic               value_neg;
    logic [WIDTH-1:0]   value_mag;
    logic [BCD_W-1:0]   bcd_adj;
    logic               fits_pos;
    logic               fits_neg;

    // Add 3 to every BCD nibble that is 5 or more. After the following left
    // shift, such a nibble carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // The magnitude is taken as WIDTH-bit unsigned. The most negative input
    // therefore negates to 2^(WIDTH-1), which is the correct magnitude.
    assign value_neg = is_signed & value[WIDTH-1];
    assign value_mag = value_neg ? (-value) : value;

    assign bcd_adj   = add3_all(bcd);

    // In FORMAT, all operand bits have been shifted into bcd. The range tests
    // therefore read the upper decimal digits directly.
    //   positive fits when the result is at most 9999 (digit 4 is zero)
    //   negative fits when the result is at most  999 (digits 4 and 3 are zero)
    assign fits_pos  = (bcd[19:16] == 4'd0);
    assign fits_neg  = (bcd[19:12] == 8'd0);

    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            neg     <= 1'b0;
            mag     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            l3      <= 4'h0;
            l2      <= 4'h0;
            l1      <= 4'h0;
            l0      <= 4'h0;
        end else begin
            // done is a pulse. Only the FORMAT branch raises it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        neg     <= value_neg;
                        mag     <= value_mag;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Shift {bcd, mag} left by one, using the adjusted BCD.
                    bcd     <= {bcd_adj[BCD_W-2:0], mag[WIDTH-1]};
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_FORMAT;
                    end
                end

                ST_FORMAT: begin
                    if (!neg && fits_pos) begin
                        l3  <= bcd[15:12];
                        l2  <= bcd[11:8];
                        l1  <= bcd[7:4];
                        l0  <= bcd[3:0];
                        ovf <= 1'b0;
                    end else if (neg && fits_neg) begin
                        l3  <= CODE_MINUS;
                        l2  <= bcd[11:8];
                        l1  <= bcd[7:4];
                        l0  <= bcd[3:0];
                        ovf <= 1'b0;
                    end else begin
                        // Out of range: show "----" and flag it.
                        l3  <= CODE_MINUS;
                        l2  <= CODE_MINUS;
                        l1  <= CODE_MINUS;
                        l0  <= CODE_MINUS;
                        ovf <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits4.sv
`timescale 1ns/1ps
module tb_bin_to_digits4;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] value;
    logic         is_signed;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [3:0]   l3, l2, l1, l0;

    int vectors     = 0;
    int miscompares = 0;

    // Expected {ovf, l3, l2, l1, l0}, pushed at launch and popped at done.
    logic [16:0] exp_q[$];

    bin_to_digits4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .l3        (l3),
        .l2        (l2),
        .l1        (l1),
        .l0        (l0)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [16:0] result();
        return {ovf, l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and then sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start pulse. Returns just after the accepting edge E0.
    task automatic launch(input logic [15:0] v, input logic s);
        value     = v;
        is_signed = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Wait for done with a bounded cycle budget. Then check the latency, the
    // result and the busy fall. On return, the bench is in the done cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int          n;
        bit          seen;
        logic [16:0] e;
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(n), 32'(exp_lat));
            check({tag, "_result"}, 32'(result()), 32'(e));
            check({tag, "_busy_low"}, 32'(busy), 32'd0);
        end
    endtask

    // Run a full conversion, then confirm that done lasts only one cycle.
    task automatic convert(input logic [15:0] v, input logic s, input logic [16:0] exp, input string tag);
        exp_q.push_back(exp);
        launch(v, s);
        wait_done(tag, W + 1);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dcnt;

        rst       = 1'b1;
        start     = 1'b0;
        value     = '0;
        is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 32'(result()), 32'h0);
        check("reset_busy",   32'(busy),     32'd0);
        check("reset_done",   32'(done),     32'd0);
        rst = 1'b0;
        tick();

        // Main function and range boundaries
        convert(16'h04D2, 1'b1, 17'h01234, "s_1234");
        convert(16'hFFD6, 1'b1, 17'h0A042, "s_m42");
        convert(16'hFC19, 1'b1, 17'h0A999, "s_m999");
        convert(16'h2710, 1'b1, 17'h1AAAA, "s_10000_ovf");
        convert(16'h0000, 1'b1, 17'h00000, "zero");
        convert(16'hFC18, 1'b1, 17'h1AAAA, "s_m1000_ovf");
        convert(16'h8000, 1'b1, 17'h1AAAA, "s_m32768_ovf");
        convert(16'hFFFF, 1'b0, 17'h1AAAA, "u_ffff_ovf");
        convert(16'h270F, 1'b0, 17'h09999, "u_9999");
        convert(16'hFFFF, 1'b1, 17'h0A001, "s_m1");
        convert(16'h270F, 1'b1, 17'h09999, "s_9999");
        convert(16'h8000, 1'b0, 17'h1AAAA, "u_32768_ovf");

        // A start while busy is ignored, and the inputs may change after E0.
        exp_q.push_back(17'h00085);
        launch(16'h0055, 1'b0);
        repeat (5) tick();
        value     = 16'h0309;
        is_signed = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        value     = 16'hFFFF;
        wait_done("busy_start_ignored", W + 1 - 6);

        // A start during the done cycle launches a new conversion.
        exp_q.push_back(17'h00321);
        launch(16'h0141, 1'b0);
        wait_done("done_cycle_start", W + 1);
        count_done(20, dcnt);
        check("no_extra_done", 32'(dcnt), 32'd0);

        // Asserting reset in cycle 8 of a conversion aborts it asynchronously.
        launch(16'h10E1, 1'b0);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_result", 32'(result()), 32'h0);
        check("midrst_busy",   32'(busy),     32'd0);
        check("midrst_done",   32'(done),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(30, dcnt);
        check("midrst_no_done", 32'(dcnt), 32'd0);
        check("midrst_idle",    32'(busy), 32'd0);
        convert(16'hFFF9, 1'b1, 17'h0A007, "after_reset");

        // Result is held while the inputs toggle with start=0.
        convert(16'h162E, 1'b0, 17'h05678, "hold_base");
        for (int i = 0; i < 100; i++) begin
            value     = 16'($urandom_range(0, 65535));
            is_signed = 1'($urandom_range(0, 1));
            tick();
            check("hold", 32'({busy, done, result()}), 32'({2'b00, 17'h05678}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
